// File: rtl/picorv_stream_pkg.sv
// Shared definitions for the PicoRV stream MMIO block: FSM states,
// register offsets inside a channel slot and STATUS bit positions.
package picorv_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TX_WAIT = 2'd1,
    RX_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Each channel owns an 8-byte slot: TX word first, RX word second.
  localparam int unsigned TX_OFS    = 0;
  localparam int unsigned RX_OFS    = 4;
  localparam int unsigned CH_STRIDE = 8;

  // STATUS layout: RX non-empty flags from bit 0, tx_ready flags from bit 8.
  localparam int unsigned STATUS_RXNE_LSB  = 0;
  localparam int unsigned STATUS_TXRDY_LSB = 8;

endpackage

// File: rtl/stream_fifo.sv
// Receive FIFO for one stream channel. rx_ready is registered from the
// next occupancy, so a full FIFO that is popped keeps in_ready low for
// that cycle and only reopens on the following one.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             pop,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             push;
  logic             pop_fire;

  assign push     = in_valid && in_ready;
  assign pop_fire = pop && (count != '0);
  assign empty    = (count == '0);
  assign out_data = mem[rd_ptr];

  // Next occupancy from this cycle's push/pop pair.
  always_comb begin
    count_nxt = count;
    case ({push, pop_fire})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and registered ready; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (pop_fire) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      in_ready <= (count_nxt != CNT_FULL);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/picorv_stream_mmio.sv
// PicoRV native-bus MMIO bridge to NUM_CH pairs of 32-bit streams.
// Per channel: TX register (write pushes a word out) and RX register
// (read pops from a receive FIFO); one STATUS register after the channels.
// Optional feature: define PICORV_STREAM_RX_IRQ_EN to drive irq[NUM_CH-1:0]
// with registered RX non-empty flags; otherwise irq is tied to zero.
module picorv_stream_mmio
  import picorv_stream_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          RX_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_valid,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic                mem_ready,
  output logic [31:0]         mem_rdata,
  output logic                mmio_hit,
  output logic [NUM_CH*32-1:0] tx_data,
  output logic [NUM_CH-1:0]   tx_valid,
  input  logic [NUM_CH-1:0]   tx_ready,
  input  logic [NUM_CH*32-1:0] rx_data,
  input  logic [NUM_CH-1:0]   rx_valid,
  output logic [NUM_CH-1:0]   rx_ready,
  output logic [31:0]         irq
);

  localparam logic [31:0] WIN_BYTES  = 32'(CH_STRIDE * NUM_CH + 4);
  localparam logic [29:0] STATUS_IDX = 30'((CH_STRIDE * NUM_CH) / 4);

  state_t      state;
  logic [2:0]  cur_ch;
  logic [31:0] off;
  logic [2:0]  req_ch;
  logic [2:0]  sub_ofs;
  logic        is_status;
  logic        is_tx_reg;
  logic        is_rx_reg;
  logic        is_write;
  logic        accept;
  logic [31:0] status_word;

  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_pop;
  logic [NUM_CH-1:0] rx_nempty;
  logic [7:0]        ne8;
  logic [31:0]       fifo_dout [8];
  logic              pop_go;
  logic [2:0]        pop_ch;

  // Address decode: window offset, channel slot and register within slot.
  assign off       = mem_addr - BASE_ADDR;
  assign mmio_hit  = (mem_addr >= BASE_ADDR) && (off < WIN_BYTES);
  assign req_ch    = 3'(off / CH_STRIDE);
  assign sub_ofs   = {off[2], 2'b00};
  assign is_status = (off[31:2] == STATUS_IDX);
  assign is_tx_reg = !is_status && (sub_ofs == 3'(TX_OFS));
  assign is_rx_reg = !is_status && (sub_ofs == 3'(RX_OFS));
  assign is_write  = |mem_wstrb;

  // mem_ready is high in the first IDLE cycle while the CPU still holds
  // mem_valid for the finished access; masking it avoids a replayed request.
  assign accept = mem_valid && mmio_hit && !mem_ready;

  assign rx_nempty = ~fifo_empty;
  assign ne8       = 8'(rx_nempty);

  // STATUS word assembled from live FIFO and stream-ready state.
  always_comb begin
    status_word = '0;
    status_word[STATUS_RXNE_LSB +: NUM_CH]  = rx_nempty;
    status_word[STATUS_TXRDY_LSB +: NUM_CH] = tx_ready;
  end

  // Pop the addressed FIFO on an immediate RX hit or when a stalled read resumes.
  always_comb begin
    pop_go = 1'b0;
    pop_ch = cur_ch;
    if (state == IDLE && accept && is_rx_reg && !is_write && ne8[req_ch]) begin
      pop_go = 1'b1;
      pop_ch = req_ch;
    end else if (state == RX_WAIT && ne8[cur_ch]) begin
      pop_go = 1'b1;
    end
  end

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_ch
    assign fifo_pop[g] = pop_go && (pop_ch == 3'(g));

    stream_fifo #(
      .WIDTH (32),
      .DEPTH (RX_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .in_data  (rx_data[g*32 +: 32]),
      .in_valid (rx_valid[g]),
      .in_ready (rx_ready[g]),
      .out_data (fifo_dout[g]),
      .pop      (fifo_pop[g]),
      .empty    (fifo_empty[g])
    );
  end

  for (g = NUM_CH; g < 8; g++) begin : g_pad
    assign fifo_dout[g] = '0;
  end

  // Control FSM: accepts one access in IDLE and answers through RESP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cur_ch    <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      tx_valid  <= '0;
      tx_data   <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_ch    <= req_ch;
            mem_rdata <= '0;
            state     <= RESP;
            if (is_tx_reg && is_write) begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (req_ch == 3'(i)) begin
                  tx_data[i*32 +: 32] <= mem_wdata;
                  tx_valid[i]         <= 1'b1;
                end
              end
              state <= TX_WAIT;
            end else if (is_rx_reg && !is_write) begin
              if (ne8[req_ch]) mem_rdata <= fifo_dout[req_ch];
              else             state     <= RX_WAIT;
            end else if (is_status && !is_write) begin
              mem_rdata <= status_word;
            end
          end
        end
        TX_WAIT: begin
          if (|(tx_valid & tx_ready)) begin
            tx_valid <= '0;
            state    <= RESP;
          end
        end
        RX_WAIT: begin
          if (ne8[cur_ch]) begin
            mem_rdata <= fifo_dout[cur_ch];
            state     <= RESP;
          end
        end
        RESP: begin
          mem_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PICORV_STREAM_RX_IRQ_EN
  logic [NUM_CH-1:0] irq_q;

  // Registered per-channel RX non-empty interrupt lines.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq_q <= '0;
    else         irq_q <= rx_nempty;
  end

  assign irq = 32'(irq_q);
`else
  assign irq = '0;
`endif

endmodule

// File: tb/tb_picorv_stream_mmio.sv
// Directed bench for picorv_stream_mmio with scoreboard queues for CPU
// read data and TX stream handshakes.
module tb_picorv_stream_mmio;

  localparam int          NUM_CH = 4;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] TX0    = BASE + 32'h00;
  localparam logic [31:0] RX0    = BASE + 32'h04;
  localparam logic [31:0] TX1    = BASE + 32'h08;
  localparam logic [31:0] RX1    = BASE + 32'h0C;
  localparam logic [31:0] TX2    = BASE + 32'h10;
  localparam logic [31:0] STAT   = BASE + 32'h20;
`ifdef PICORV_STREAM_RX_IRQ_EN
  localparam logic [31:0] EXP_IRQ = 32'h9;
`else
  localparam logic [31:0] EXP_IRQ = 32'h0;
`endif

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 mem_valid;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wstrb;
  logic                 mem_ready;
  logic [31:0]          mem_rdata;
  logic                 mmio_hit;
  logic [NUM_CH*32-1:0] tx_data;
  logic [NUM_CH-1:0]    tx_valid;
  logic [NUM_CH-1:0]    tx_ready;
  logic [NUM_CH*32-1:0] rx_data;
  logic [NUM_CH-1:0]    rx_valid;
  logic [NUM_CH-1:0]    rx_ready;
  logic [31:0]          irq;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } tx_exp_t;

  logic [31:0] exp_q [$];
  tx_exp_t     tx_q [$];
  int checks = 0;
  int failures = 0;
  int txv0_cnt = 0;
  int rdy1_cnt = 0;

  picorv_stream_mmio #(
    .NUM_CH    (NUM_CH),
    .RX_DEPTH  (8),
    .BASE_ADDR (BASE)
  ) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mmio_hit  (mmio_hit),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tx_expect(input int ch, input logic [31:0] d);
    tx_exp_t e;
    e.ch   = ch;
    e.data = d;
    tx_q.push_back(e);
  endtask

  // One CPU access; lat counts clock edges from request to mem_ready.
  task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                            output int lat);
    @(posedge clk); #1;
    exp_q.push_back(exp_rdata);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ready && lat < 200);
    if (!mem_ready) begin
      checks++;
      failures++;
      $display("FAIL cpu_timeout: addr %0h got no mem_ready required within 200 cycles", addr);
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic rx_push(input int ch, input logic [31:0] d);
    int   n;
    logic r;
    @(posedge clk); #1;
    rx_data[ch*32 +: 32] = d;
    rx_valid[ch] = 1'b1;
    n = 0;
    r = 1'b0;
    do begin
      @(negedge clk);
      r = rx_ready[ch];
      @(posedge clk); #1;
      n++;
    end while (!r && n < 100);
    if (!r) begin
      checks++;
      failures++;
      $display("FAIL rx_push_timeout: ch %0d rx_ready got 0 required 1", ch);
    end
    rx_valid[ch] = 1'b0;
  endtask

  // Monitor: read-data scoreboard, TX handshake scoreboard, TX stability.
  initial begin
    logic [NUM_CH-1:0] prev_v;
    logic [NUM_CH-1:0] prev_fire;
    logic [31:0]       prev_d [NUM_CH];
    logic [31:0]       e;
    tx_exp_t           te;
    prev_v    = '0;
    prev_fire = '0;
    for (int i = 0; i < NUM_CH; i++) prev_d[i] = '0;
    forever begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rdata_unexpected: got mem_ready with rdata %0h, required no response", mem_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", mem_rdata, e);
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (tx_valid[i] === 1'b1 && prev_v[i] && !prev_fire[i])
          chk("tx_stable", tx_data[i*32 +: 32], prev_d[i]);
        if (tx_valid[i] === 1'b1 && tx_ready[i] === 1'b1) begin
          if (tx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected: ch %0d data %0h, required no transfer", i, tx_data[i*32 +: 32]);
          end else begin
            te = tx_q.pop_front();
            chk("tx_ch", i, te.ch);
            chk("tx_data", tx_data[i*32 +: 32], te.data);
          end
        end
        prev_v[i]    = (tx_valid[i] === 1'b1);
        prev_d[i]    = tx_data[i*32 +: 32];
        prev_fire[i] = (tx_valid[i] === 1'b1) && (tx_ready[i] === 1'b1);
      end
      if (tx_valid[0] === 1'b1) txv0_cnt++;
      if (rx_ready[1] === 1'b1) rdy1_cnt++;
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int c0;
    int bad;
    int n;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    tx_ready  = 4'hF;
    rx_valid  = '0;
    rx_data   = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_irq", irq, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_tx_data", tx_data, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // TX write with ready already high
    #1;
    c0 = txv0_cnt;
    tx_expect(0, 32'hDEAD_BEEF);
    cpu_access(TX0, 32'hDEAD_BEEF, 4'hF, 32'h0, lat);
    chk("tx_lat", lat, 3);
    @(posedge clk); #1;
    chk("tx_valid_cycles", txv0_cnt - c0, 1);

    // TX backpressure on channel 2
    tx_ready[2] = 1'b0;
    tx_expect(2, 32'hCAFE_0002);
    fork
      cpu_access(TX2, 32'hCAFE_0002, 4'hF, 32'h0, lat);
      begin
        repeat (2) @(posedge clk);
        bad = 0;
        repeat (10) begin
          @(negedge clk);
          if (mem_ready !== 1'b0 || tx_valid[2] !== 1'b1 || tx_data[95:64] !== 32'hCAFE_0002) bad++;
        end
        chk("bp_hold", bad, 0);
        @(posedge clk); #1;
        tx_ready[2] = 1'b1;
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!mem_ready && n < 20);
        chk("bp_resp_lat", n, 2);
      end
    join

    // Fill channel 1, drain in order, then stall on empty
    for (int k = 1; k <= 8; k++) rx_push(1, 32'(k));
    @(negedge clk);
    chk("fill_rx_ready", rx_ready[1], 0);
    for (int k = 1; k <= 8; k++) begin
      cpu_access(RX1, 32'h0, 4'h0, 32'(k), lat);
      chk("rx_lat", lat, 2);
    end
    fork
      begin
        cpu_access(RX1, 32'h0, 4'h0, 32'd9, lat);
        chk("rx_stall_lat", lat, 9);
      end
      begin
        repeat (6) @(posedge clk);
        rx_push(1, 32'd9);
      end
    join

    // Pop a full FIFO while a push is pending
    for (int k = 0; k < 8; k++) rx_push(1, 32'h10 + 32'(k));
    @(negedge clk);
    chk("full_rx_ready", rx_ready[1], 0);
    @(posedge clk); #1;
    c0 = rdy1_cnt;
    fork
      rx_push(1, 32'h18);
      begin
        cpu_access(RX1, 32'h0, 4'h0, 32'h10, lat);
        chk("full_pop_lat", lat, 2);
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("full_pop_ready_cycles", rdy1_cnt - c0, 1);
    chk("refill_rx_ready", rx_ready[1], 0);
    for (int k = 1; k <= 8; k++) cpu_access(RX1, 32'h0, 4'h0, 32'h10 + 32'(k), lat);

    // STATUS, IRQ and no-side-effect accesses
    tx_ready = 4'b0101;
    rx_push(0, 32'hA0);
    rx_push(3, 32'hA3);
    cpu_access(STAT, 32'h0, 4'h0, 32'h0000_0509, lat);
    chk("status_lat", lat, 2);
    @(posedge clk); #1;
    chk("irq", irq, EXP_IRQ);
    cpu_access(TX1, 32'h0, 4'h0, 32'h0, lat);
    chk("tx_read_lat", lat, 2);
    chk("tx_read_no_valid", tx_valid, 0);
    cpu_access(RX0, 32'h55, 4'hF, 32'h0, lat);
    chk("rx_write_lat", lat, 2);
    cpu_access(STAT, 32'hFFFF, 4'hF, 32'h0, lat);
    cpu_access(STAT, 32'h0, 4'h0, 32'h0000_0509, lat);
    mem_addr = BASE + 32'h23; #1;
    chk("hit_top", mmio_hit, 1);
    mem_addr = BASE + 32'h24; #1;
    chk("hit_above", mmio_hit, 0);
    mem_addr = BASE - 32'h4; #1;
    chk("hit_below", mmio_hit, 0);
    mem_addr = BASE + 32'h14; #1;
    chk("hit_mid", mmio_hit, 1);

    // Reset in the middle of a TX handshake with buffered RX data
    rx_push(2, 32'hA2);
    @(posedge clk); #1;
    mem_addr  = TX1;
    mem_wdata = 32'h1111_2222;
    mem_wstrb = 4'hF;
    mem_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_tx_valid", tx_valid[1], 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_rx_ready", rx_ready, 0);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    repeat (2) @(posedge clk); #1;
    resetn   = 1'b1;
    tx_ready = 4'h0;
    cpu_access(STAT, 32'h0, 4'h0, 32'h0, lat);
    chk("post_rst_status_lat", lat, 2);
    @(posedge clk); #1;
    chk("post_rst_irq", irq, 0);

    @(posedge clk); #1;
    chk("rdata_queue_drained", exp_q.size(), 0);
    chk("tx_queue_drained", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
